// File: rtl/trace_recorder.sv
// Records a dwell-filtered cursor path over the 4x4 spell-trace grid:
// a bitmap of visited boxes plus the ordered list of up to 8 accepted boxes.
module trace_recorder #(
  parameter int unsigned DWELL   = 4,
  parameter int unsigned TIMEOUT = 50_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        stop,
  input  logic        cur_valid,
  input  logic [8:0]  cur_row,
  input  logic [9:0]  cur_col,
  output logic [15:0] trace,
  output logic [31:0] seq,
  output logic [3:0]  seq_len,
  output logic        busy,
  output logic        done
);

  localparam int unsigned   TW        = $clog2(TIMEOUT);
  localparam logic [3:0]    DWELL_C   = 4'(DWELL);
  localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RECORD = 2'd1, DONE = 2'd2} state_t;

  // Band decode returns {in_band, band_index}; comparisons only.
  function automatic logic [2:0] band_row(input logic [8:0] row);
    logic [2:0] r;
    if (row < 9'd40)       r = 3'b000;
    else if (row < 9'd140) r = 3'b100;
    else if (row < 9'd240) r = 3'b101;
    else if (row < 9'd340) r = 3'b110;
    else if (row < 9'd440) r = 3'b111;
    else                   r = 3'b000;
    return r;
  endfunction

  function automatic logic [2:0] band_col(input logic [9:0] col);
    logic [2:0] c;
    if (col < 10'd120)      c = 3'b000;
    else if (col < 10'd220) c = 3'b100;
    else if (col < 10'd320) c = 3'b101;
    else if (col < 10'd420) c = 3'b110;
    else if (col < 10'd520) c = 3'b111;
    else                    c = 3'b000;
    return c;
  endfunction

  state_t        state_r, state_s;
  logic [15:0]   trace_r, trace_s;
  logic [31:0]   seq_r, seq_s;
  logic [3:0]    seq_len_r, seq_len_s;
  logic [3:0]    last_box_r, last_box_s;
  logic [3:0]    cand_r, cand_s;
  logic          cand_valid_r, cand_valid_s;
  logic [3:0]    count_r, count_s;
  logic [TW-1:0] timer_r, timer_s;
  logic          busy_r, done_r;

  logic [2:0] row_band_s, col_band_s;
  logic       in_grid_s, hit_s, reach_s, accept_s;
  logic [3:0] box_s, dwell_next_s;

  assign row_band_s   = band_row(cur_row);
  assign col_band_s   = band_col(cur_col);
  assign in_grid_s    = row_band_s[2] & col_band_s[2];
  assign box_s        = {row_band_s[1:0], col_band_s[1:0]};
  assign hit_s        = cand_valid_r && (box_s == cand_r);
  assign dwell_next_s = hit_s ? ((count_r == DWELL_C) ? DWELL_C : count_r + 4'd1) : 4'd1;
  // A saturated count on the same box is not a new accept.
  assign reach_s      = cur_valid && in_grid_s && (dwell_next_s == DWELL_C)
                        && !(hit_s && (count_r == DWELL_C));
  assign accept_s     = reach_s && ((seq_len_r == 4'd0) || (box_s != last_box_r));

  // Next-state and next-result logic for the recorder.
  always_comb begin
    state_s      = state_r;
    trace_s      = trace_r;
    seq_s        = seq_r;
    seq_len_s    = seq_len_r;
    last_box_s   = last_box_r;
    cand_s       = cand_r;
    cand_valid_s = cand_valid_r;
    count_s      = count_r;
    timer_s      = timer_r;
    if (start) begin
      trace_s      = 16'h0000;
      seq_s        = 32'h0000_0000;
      seq_len_s    = 4'd0;
      last_box_s   = 4'd0;
      cand_s       = 4'd0;
      cand_valid_s = 1'b0;
      count_s      = 4'd0;
      timer_s      = '0;
      state_s      = RECORD;
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        RECORD: begin
          if (cur_valid && in_grid_s) begin
            cand_s       = box_s;
            cand_valid_s = 1'b1;
            count_s      = dwell_next_s;
          end else if (cur_valid) begin
            cand_valid_s = 1'b0;
            count_s      = 4'd0;
          end else begin
            cand_valid_s = cand_valid_r;
            count_s      = count_r;
          end
          if (accept_s) begin
            seq_s[{seq_len_r[2:0], 2'b00} +: 4] = box_s;
            seq_len_s      = seq_len_r + 4'd1;
            trace_s[box_s] = 1'b1;
            last_box_s     = box_s;
            timer_s        = '0;
          end else if (seq_len_r != 4'd0) begin
            timer_s = timer_r + TW'(1'b1);
          end else begin
            timer_s = timer_r;
          end
          if (stop || (accept_s && (seq_len_r == 4'd7))
              || (!accept_s && (seq_len_r != 4'd0) && (timer_r == TIMER_END))) begin
            state_s = DONE;
          end else begin
            state_s = RECORD;
          end
        end
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= IDLE;
      trace_r      <= 16'h0000;
      seq_r        <= 32'h0000_0000;
      seq_len_r    <= 4'd0;
      last_box_r   <= 4'd0;
      cand_r       <= 4'd0;
      cand_valid_r <= 1'b0;
      count_r      <= 4'd0;
      timer_r      <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      trace_r      <= trace_s;
      seq_r        <= seq_s;
      seq_len_r    <= seq_len_s;
      last_box_r   <= last_box_s;
      cand_r       <= cand_s;
      cand_valid_r <= cand_valid_s;
      count_r      <= count_s;
      timer_r      <= timer_s;
      busy_r       <= (state_s == RECORD);
      done_r       <= (state_s == DONE);
    end
  end

  assign trace   = trace_r;
  assign seq     = seq_r;
  assign seq_len = seq_len_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_trace_recorder.sv
// Directed bench for trace_recorder: vector table for paths and grid edges,
// hand sequences for timeout, eight-accept end and mid-recording reset.
module tb_trace_recorder;

  logic        clk = 1'b0;
  logic        resetn, start, stop, cur_valid;
  logic [8:0]  cur_row;
  logic [9:0]  cur_col;
  logic [15:0] trace;
  logic [31:0] seq;
  logic [3:0]  seq_len;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  trace_recorder #(.DWELL(4), .TIMEOUT(100)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .cur_valid(cur_valid), .cur_row(cur_row), .cur_col(cur_col),
    .trace(trace), .seq(seq), .seq_len(seq_len), .busy(busy), .done(done)
  );

  typedef struct {
    logic        st;
    logic        sp;
    logic        vld;
    logic [8:0]  row;
    logic [9:0]  col;
    int          reps;
    logic [15:0] e_trace;
    logic [31:0] e_seq;
    logic [3:0]  e_len;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic sp, logic vld, logic [8:0] row, logic [9:0] col,
                              int reps, logic [15:0] et, logic [31:0] es, logic [3:0] el,
                              logic eb, logic ed);
    vec_t v;
    v.st = st; v.sp = sp; v.vld = vld; v.row = row; v.col = col; v.reps = reps;
    v.e_trace = et; v.e_seq = es; v.e_len = el; v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] et, input logic [31:0] es,
                           input logic [3:0] el, input logic eb, input logic ed);
    check({tag, ".trace"},   {16'h0, trace},  {16'h0, et});
    check({tag, ".seq"},     seq,             es);
    check({tag, ".seq_len"}, {28'h0, seq_len}, {28'h0, el});
    check({tag, ".busy"},    {31'h0, busy},   {31'h0, eb});
    check({tag, ".done"},    {31'h0, done},   {31'h0, ed});
  endtask

  task automatic drive(input logic st, input logic sp, input logic vld,
                       input logic [8:0] row, input logic [9:0] col, input int reps);
    for (int k = 0; k < reps; k++) begin
      start = st; stop = sp; cur_valid = vld; cur_row = row; cur_col = col;
      @(posedge clk);
      #1;
    end
    start = 1'b0; stop = 1'b0; cur_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    logic got;

    resetn = 1'b0; start = 1'b0; stop = 1'b0; cur_valid = 1'b0;
    cur_row = 9'd0; cur_col = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 16'h0000, 32'h0, 4'd0, 1'b0, 1'b0);
    resetn = 1'b1;

    // Single dwell in box 0.
    vecs.push_back(mk(1, 0, 0,   0,   0, 1, 16'h0000, 32'h0,     0, 1, 0));
    vecs.push_back(mk(0, 0, 1,  90, 170, 3, 16'h0000, 32'h0,     0, 1, 0));
    vecs.push_back(mk(0, 0, 1,  90, 170, 1, 16'h0001, 32'h0,     1, 1, 0));
    // Interrupted dwell: only box 15 accepted.
    vecs.push_back(mk(1, 0, 0,   0,   0, 1, 16'h0000, 32'h0,     0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 390, 470, 3, 16'h0000, 32'h0,     0, 1, 0));
    vecs.push_back(mk(0, 0, 1,  90, 170, 1, 16'h0000, 32'h0,     0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 390, 470, 3, 16'h0000, 32'h0,     0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 390, 470, 1, 16'h8000, 32'hF,     1, 1, 0));
    // Path 0 -> 5 -> 10 -> 15 -> 10, then stop, then start during DONE.
    vecs.push_back(mk(1, 0, 0,   0,   0, 1, 16'h0000, 32'h0,     0, 1, 0));
    vecs.push_back(mk(0, 0, 1,  90, 170, 4, 16'h0001, 32'h0,     1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 190, 270, 4, 16'h0021, 32'h50,    2, 1, 0));
    vecs.push_back(mk(0, 0, 1, 290, 370, 4, 16'h0421, 32'hA50,   3, 1, 0));
    vecs.push_back(mk(0, 0, 1, 390, 470, 4, 16'h8421, 32'hFA50,  4, 1, 0));
    vecs.push_back(mk(0, 0, 1, 290, 370, 4, 16'h8421, 32'hAFA50, 5, 1, 0));
    vecs.push_back(mk(0, 1, 0,   0,   0, 1, 16'h8421, 32'hAFA50, 5, 0, 1));
    vecs.push_back(mk(1, 0, 0,   0,   0, 1, 16'h0000, 32'h0,     0, 1, 0));
    vecs.push_back(mk(0, 0, 0,   0,   0, 1, 16'h0000, 32'h0,     0, 1, 0));
    // Grid edges, out-of-grid reset of dwell, hold on invalid samples, no consecutive repeat.
    vecs.push_back(mk(0, 0, 1,  40, 120, 3, 16'h0000, 32'h0,     0, 1, 0));
    vecs.push_back(mk(0, 0, 1,  40, 119, 1, 16'h0000, 32'h0,     0, 1, 0));
    vecs.push_back(mk(0, 0, 1,  40, 120, 3, 16'h0000, 32'h0,     0, 1, 0));
    vecs.push_back(mk(0, 0, 1,  40, 120, 1, 16'h0001, 32'h0,     1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 439, 519, 4, 16'h8001, 32'hF0,    2, 1, 0));
    vecs.push_back(mk(0, 0, 1, 140, 220, 2, 16'h8001, 32'hF0,    2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 390, 470, 5, 16'h8001, 32'hF0,    2, 1, 0));
    vecs.push_back(mk(0, 0, 1, 140, 220, 1, 16'h8001, 32'hF0,    2, 1, 0));
    vecs.push_back(mk(0, 0, 1, 140, 220, 1, 16'h8021, 32'h5F0,   3, 1, 0));
    vecs.push_back(mk(0, 0, 1, 440, 120, 4, 16'h8021, 32'h5F0,   3, 1, 0));
    vecs.push_back(mk(0, 0, 1, 140, 220, 4, 16'h8021, 32'h5F0,   3, 1, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].vld, vecs[i].row, vecs[i].col, vecs[i].reps);
      check_all($sformatf("vec%0d", i), vecs[i].e_trace, vecs[i].e_seq, vecs[i].e_len,
                vecs[i].e_busy, vecs[i].e_done);
    end

    // Timeout: accept box 0, keep dwelling there, done must come 100 cycles after the accept.
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 90, 170, 4);
    check_all("to_accept", 16'h0001, 32'h0, 4'd1, 1'b1, 1'b0);
    cnt = 0;
    got = 1'b0;
    for (int k = 1; k <= 200 && !got; k++) begin
      cur_valid = (k <= 8); cur_row = 9'd90; cur_col = 10'd170;
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        cnt = k;
      end
    end
    cur_valid = 1'b0;
    check("to_cycles", cnt, 32'd100);
    check_all("to_done", 16'h0001, 32'h0, 4'd1, 1'b0, 1'b1);
    drive(0, 0, 0, 0, 0, 1);
    check_all("to_after", 16'h0001, 32'h0, 4'd1, 1'b0, 1'b0);

    // Eight alternating accepts end the recording; later samples are ignored.
    drive(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive(0, 0, 1, 90, 270, 4);
      else            drive(0, 0, 1, 90, 370, 4);
      if (i == 6) check_all("alt7", 16'h0006, 32'h0121_2121, 4'd7, 1'b1, 1'b0);
    end
    check_all("alt8", 16'h0006, 32'h2121_2121, 4'd8, 1'b0, 1'b1);
    drive(0, 0, 1, 90, 470, 4);
    check_all("alt_ignored", 16'h0006, 32'h2121_2121, 4'd8, 1'b0, 1'b0);

    // Reset mid-recording clears everything and blocks samples until start.
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 90, 170, 4);
    drive(0, 0, 1, 90, 270, 4);
    drive(0, 0, 1, 90, 370, 4);
    check_all("pre_rst", 16'h0007, 32'h210, 4'd3, 1'b1, 1'b0);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check_all("mid_rst", 16'h0000, 32'h0, 4'd0, 1'b0, 1'b0);
    resetn = 1'b1;
    drive(0, 0, 1, 90, 170, 4);
    check_all("post_rst", 16'h0000, 32'h0, 4'd0, 1'b0, 1'b0);
    drive(1, 0, 0, 0, 0, 1);
    check_all("restart", 16'h0000, 32'h0, 4'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_recorder.md
# trace_recorder

Records a wand/cursor path into the 4x4 spell-trace grid. It samples a tracked screen position in VGA coordinates and decides which grid box the cursor dwells in. It then sets the matching bit of the 16-bit `trace` vector consumed by the trace display, and keeps the ordered list of visited boxes for spell matching. It sits between the cursor tracker and both the trace display and the spell matcher.

## Interface
Parameters:
- `DWELL`, 4: consecutive valid in-box samples required before a box is accepted (1..15).
- `TIMEOUT`, 50_000_000: cycles without a new accepted box that end a recording, counted only after the first accept (>= 2).

Ports:
- `clk` in 1: system clock; single clock domain.
- `resetn` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse; clears results and begins or restarts recording.
- `stop` in 1: one-cycle pulse; ends recording.
- `cur_valid` in 1: `cur_row`/`cur_col` hold a new cursor sample this cycle.
- `cur_row` in 9: cursor row, 0..479.
- `cur_col` in 10: cursor column, 0..639.
- `trace` out 16: bit b set once box b has been accepted.
- `seq` out 32: nibble k (`seq[4k+3:4k]`) is the k-th accepted box index.
- `seq_len` out 4: number of valid nibbles in `seq`, 0..8.
- `busy` out 1: high while in RECORD.
- `done` out 1: one-cycle pulse when a recording ends.

## Operation
- Grid geometry:
  - Valid area is rows [40,440) and cols [120,520).
  - Box row r = 0..3 for rows [40,140), [140,240), [240,340), [340,440).
  - Box column c = 0..3 for cols [120,220), [220,320), [320,420), [420,520).
  - Box index b = 4r + c, so box 0 is top-left and box 15 is bottom-right.
  - Decode uses comparisons only; no dividers.
- States are IDLE, RECORD and DONE.
- IDLE: `busy`=0. Outputs hold the last recording so the display keeps showing it. `start` clears `trace`, `seq`, `seq_len`, the dwell state, the timer and `last_box`, then goes to RECORD.
- RECORD: `busy`=1.
  - Dwell filter, applied on `cur_valid`=1 samples only:
    - In-grid sample with b equal to the candidate: the count increments, saturating at `DWELL`.
    - In-grid sample with b different from the candidate: candidate becomes b and count becomes 1.
    - Out-of-grid sample: the candidate is invalidated and count becomes 0.
    - `cur_valid`=0: all dwell state holds.
  - Accept happens on the sample where the count becomes exactly `DWELL`. It takes effect only if `seq_len`=0 or b differs from `last_box`. Accepting does all of the following:
    - writes `seq` nibble `seq_len` with b;
    - increments `seq_len`;
    - sets `trace[b]`;
    - sets `last_box` to b;
    - clears the timer.
  - Re-entering an earlier, non-consecutive box appends again; `trace[b]` is already set and stays set.
  - The timer increments each cycle once `seq_len` is at least 1.
  - Go to DONE on any of these:
    - `stop`=1;
    - the accept that brings `seq_len` to 8;
    - the timer reaching `TIMEOUT`-1.
- DONE: lasts one cycle with `done`=1 and `busy`=0, then returns to IDLE.
- Priority:
  - `start` overrides everything in every state. In RECORD it restarts (clears results, stays in RECORD). In DONE it still pulses `done` and then enters RECORD instead of IDLE.
  - When `stop` and an accept happen in the same cycle, the accept is recorded and the block then ends.
- Reset (`resetn`=0 at a clock edge) is valid in any state, including mid-recording. It sets state to IDLE and clears `trace`, `seq`, `seq_len`, `busy`, `done`, the dwell state and the timer.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Accept latency: for the `DWELL`-th consecutive sample registered at edge E, `trace`, `seq` and `seq_len` show the update right after E.
- Start latency: `start` at edge E gives `busy`=1 and cleared outputs right after E.
- End latency: a stop, 8th accept or timeout registered at edge E gives `done`=1 and `busy`=0 for exactly the cycle after E.
- Timeout: `TIMEOUT` cycles after the last accept.
- Samples arriving outside RECORD are ignored.

## Test plan
- Reset, then `DWELL`=4 and `start`, then 4 valid samples at (90,170) -> `trace`=0x0001, `seq_len`=1, `seq[3:0]`=0.
- 3 samples at (390,470), then 1 at (90,170), then 4 at (390,470) -> only box 15 accepted: `trace`=0x8000, `seq_len`=1.
- Path box 0 -> 5 -> 10 -> 15 -> 10 with dwell each -> `trace`=0x8421, `seq`=0x0000_AFA50, `seq_len`=5, then `stop` -> `done` one cycle, `busy`=0.
- Dwell box 0, then 8 more samples at (90,170), then `TIMEOUT`=100 idle cycles -> `seq_len`=1, no duplicate entry, `done` exactly 100 cycles after the accept.
- Alternate boxes 1/2 until 8 accepts -> `seq`=0x2121_2121, `done` on the next cycle, and a further dwell in box 3 is ignored.
- Deassert `resetn` mid-recording with `seq_len`=3 -> all outputs 0 after the edge; samples afterwards are ignored until `start`.
